slow_tick_bcd_counter: RTL and testbench

- Four-digit BCD up/down counter, directly downstream of the speed-selectable clock divider.
- Samples the divider's `clk_slow` square wave into the `clk_50MHz` domain and advances one count per `clk_slow` rising edge.
- Drives four active-low seven-segment displays (HEX3..HEX0).
- Does not use `clk_slow` as a clock: it is treated as data and edge-detected.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/slow_tick_bcd_counter_if.sv | 28 ++
 rtl/seg7_decode.sv | 29 ++
 rtl/slow_tick_bcd_counter.sv | 176 +++++++++++++++++
 tb/tb_slow_tick_bcd_counter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: active-low segment
// patterns {g,f,e,d,c,b,a}, the counter control states and BCD helpers.
package seg7_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } ctrl_state_t;

   // Decimal integer to four packed BCD digits, thousands in [15:12].
   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/slow_tick_bcd_counter_if.sv
// Control and display bundle of the slow-tick BCD counter; the driver side
// (divider glue or bench) takes master, the counter takes slave.
interface slow_tick_bcd_counter_if;

   logic        clk_slow;
   logic        enable;
   logic        up_down;
   logic        clear;
   logic        load;
   logic [15:0] load_bcd;
   logic [15:0] bcd;
   logic [6:0]  hex0;
   logic [6:0]  hex1;
   logic [6:0]  hex2;
   logic [6:0]  hex3;
   logic        tc_pulse;

   modport master (
      output clk_slow, enable, up_down, clear, load, load_bcd,
      input  bcd, hex0, hex1, hex2, hex3, tc_pulse
   );

   modport slave (
      input  clk_slow, enable, up_down, clear, load, load_bcd,
      output bcd, hex0, hex1, hex2, hex3, tc_pulse
   );

endinterface

// File: rtl/seg7_decode.sv
// One BCD digit plus blank flag to an active-low seven-segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               blank,
   output logic [6:0]         seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/slow_tick_bcd_counter.sv
// Four-digit BCD up/down counter advanced by rising edges of the divider's
// clk_slow, which is sampled as asynchronous data; drives four 7-seg digits.
module slow_tick_bcd_counter
   import seg7_pkg::*;
#(
   parameter int MAX_COUNT   = 9999,  // 1..9999
   parameter int SYNC_STAGES = 2,     // >= 2
   parameter int BLANK_LZ    = 0
) (
   input  logic                    clk_50MHz,
   input  logic                    reset,
   slow_tick_bcd_counter_if.slave  bus
);

   localparam logic [15:0] MAX_BCD = to_bcd(MAX_COUNT);
   localparam int          ARM_W   = $clog2(SYNC_STAGES + 1) + 1;

   ctrl_state_t            state;
   logic [ARM_W-1:0]       arm_cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   tick_q;
   logic [15:0]            bcd_q;
   logic                   tc_q;
   logic [15:0]            load_clean;
   logic [3:0]             blank_d;
   logic [6:0]             seg_d [4];
   logic [6:0]             hex_q [4];

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[i*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (r[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
               r[i*DIGIT_W +: DIGIT_W] = 4'd9;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // ARM holds off counting until the synchroniser and edge flop carry real
   // samples, so a clk_slow already high at reset release is not a tick.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         state   <= ARM;
         arm_cnt <= '0;
      end else if (state == ARM) begin
         if (arm_cnt == ARM_W'(SYNC_STAGES)) begin
            state <= RUN;
         end else begin
            arm_cnt <= arm_cnt + 1'b1;
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop in the
   // chain samples its predecessor's pre-edge value.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_slow};
         edge_q <= sync_q[SYNC_STAGES-1];
         tick_q <= (state == RUN) && sync_q[SYNC_STAGES-1] && !edge_q;
      end
   end

   // NOTE: the default assignment first keeps this combinational block from
   // inferring a latch on any path.
   always_comb begin
      load_clean = '0;
      for (int i = 0; i < 4; i++) begin
         load_clean[i*DIGIT_W +: DIGIT_W] =
            (bus.load_bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) ? 4'd9
                                                        : bus.load_bcd[i*DIGIT_W +: DIGIT_W];
      end
      if (load_clean > MAX_BCD) begin
         load_clean = MAX_BCD;
      end
   end

   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         bcd_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         tc_q <= 1'b0;
         if (state == RUN) begin
            if (bus.clear) begin
               bcd_q <= '0;
            end else if (bus.load) begin
               bcd_q <= load_clean;
            end else if (tick_q && bus.enable) begin
               if (bus.up_down) begin
                  if (bcd_q == MAX_BCD) begin
                     bcd_q <= '0;
                     tc_q  <= 1'b1;
                  end else begin
                     bcd_q <= bcd_inc(bcd_q);
                  end
               end else begin
                  if (bcd_q == '0) begin
                     bcd_q <= MAX_BCD;
                     tc_q  <= 1'b1;
                  end else begin
                     bcd_q <= bcd_dec(bcd_q);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      blank_d[3] = (BLANK_LZ != 0) && (bcd_q[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (bcd_q[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (bcd_q[7:4] == 4'd0);
      blank_d[0] = 1'b0;
   end

   for (genvar g = 0; g < 4; g++) begin : g_digit
      seg7_decode u_dec (
         .digit (bcd_q[g*DIGIT_W +: DIGIT_W]),
         .blank (blank_d[g]),
         .seg   (seg_d[g])
      );
   end

   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         hex_q[0] <= SEG_0;
         for (int i = 1; i < 4; i++) begin
            hex_q[i] <= (BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            hex_q[i] <= seg_d[i];
         end
      end
   end

   assign bus.bcd      = bcd_q;
   assign bus.tc_pulse = tc_q;
   assign bus.hex0     = hex_q[0];
   assign bus.hex1     = hex_q[1];
   assign bus.hex2     = hex_q[2];
   assign bus.hex3     = hex_q[3];

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Bench for slow_tick_bcd_counter: three instances (default, MAX_COUNT=59,
// BLANK_LZ=1) share one stimulus; a decimal model feeds a scoreboard queue.
module tb_slow_tick_bcd_counter;

   logic        clk_50MHz = 1'b0;
   logic        reset;
   logic        clk_slow, enable, up_down, clear, load;
   logic [15:0] load_bcd;

   always #10 clk_50MHz = ~clk_50MHz;

   slow_tick_bcd_counter_if bus [3] ();

   logic [15:0] obs_bcd [3];
   logic        obs_tc  [3];
   logic [6:0]  obs_hex [3][4];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].clk_slow = clk_slow;
      assign bus[g].enable   = enable;
      assign bus[g].up_down  = up_down;
      assign bus[g].clear    = clear;
      assign bus[g].load     = load;
      assign bus[g].load_bcd = load_bcd;
      assign obs_bcd[g]      = bus[g].bcd;
      assign obs_tc[g]       = bus[g].tc_pulse;
      assign obs_hex[g][0]   = bus[g].hex0;
      assign obs_hex[g][1]   = bus[g].hex1;
      assign obs_hex[g][2]   = bus[g].hex2;
      assign obs_hex[g][3]   = bus[g].hex3;

      slow_tick_bcd_counter #(
         .MAX_COUNT   ((g == 1) ? 59 : 9999),
         .SYNC_STAGES (2),
         .BLANK_LZ    ((g == 2) ? 1 : 0)
      ) u_dut (
         .clk_50MHz (clk_50MHz),
         .reset     (reset),
         .bus       (bus[g])
      );
   end

   typedef struct {
      string       tag;
      int          dut;
      logic [15:0] bcd;
      logic        tc;
   } exp_t;

   exp_t       sb [$];
   int         model  [3];
   logic       tc_exp [3];
   int         max_of [3] = '{9999, 59, 9999};
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dec2bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] exp_hex(input int v, input int pos, input bit blank);
      int p;
      p = 1;
      for (int i = 0; i < pos; i++) p = p * 10;
      if (blank && pos > 0 && v < p) return 7'h7F;
      return seg_tab[(v / p) % 10];
   endfunction

   task automatic push_all(input string tag);
      for (int d = 0; d < 3; d++) begin
         sb.push_back('{tag, d, dec2bcd(model[d]), tc_exp[d]});
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check($sformatf("%s.bcd[%0d]", e.tag, e.dut), 32'(obs_bcd[e.dut]), 32'(e.bcd));
         check($sformatf("%s.tc[%0d]", e.tag, e.dut), 32'(obs_tc[e.dut]), 32'(e.tc));
      end
   endtask

   task automatic check_hex(input string tag);
      for (int d = 0; d < 3; d++) begin
         for (int p = 0; p < 4; p++) begin
            check($sformatf("%s.hex%0d[%0d]", tag, p, d), 32'(obs_hex[d][p]),
                  32'(exp_hex(model[d], p, d == 2)));
         end
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         model[d]  = 0;
         tc_exp[d] = 1'b0;
      end
   endtask

   task automatic model_tick();
      for (int d = 0; d < 3; d++) begin
         tc_exp[d] = 1'b0;
         if (enable) begin
            if (up_down) begin
               if (model[d] == max_of[d]) begin
                  model[d]  = 0;
                  tc_exp[d] = 1'b1;
               end else begin
                  model[d]++;
               end
            end else begin
               if (model[d] == 0) begin
                  model[d]  = max_of[d];
                  tc_exp[d] = 1'b1;
               end else begin
                  model[d]--;
               end
            end
         end
      end
   endtask

   task automatic model_load(input logic [15:0] v, input bit do_clear);
      for (int d = 0; d < 3; d++) begin
         int val;
         val = 0;
         for (int i = 3; i >= 0; i--) begin
            int n;
            n   = int'(v[i*4 +: 4]);
            val = val * 10 + ((n > 9) ? 9 : n);
         end
         if (val > max_of[d]) val = max_of[d];
         model[d]  = do_clear ? 0 : val;
         tc_exp[d] = 1'b0;
      end
   endtask

   task automatic tick(input string tag);
      int old [3];
      for (int d = 0; d < 3; d++) old[d] = model[d];
      model_tick();
      push_all(tag);
      clk_slow = 1'b1;
      repeat (3) @(negedge clk_50MHz);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s.early[%0d]", tag, d), 32'(obs_bcd[d]), 32'(dec2bcd(old[d])));
      end
      @(negedge clk_50MHz);
      drain();
      @(negedge clk_50MHz);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s.tc_off[%0d]", tag, d), 32'(obs_tc[d]), 32'd0);
      end
      check_hex(tag);
      clk_slow = 1'b0;
      repeat (3) @(negedge clk_50MHz);
   endtask

   task automatic load_op(input string tag, input logic [15:0] v, input bit do_clear,
                          input bit do_load);
      model_load(v, do_clear);
      push_all(tag);
      clear    = do_clear;
      load     = do_load;
      load_bcd = v;
      @(negedge clk_50MHz);
      clear = 1'b0;
      load  = 1'b0;
      drain();
      @(negedge clk_50MHz);
      check_hex(tag);
   endtask

   // The tick reaches the counter on the same edge as clear/load.
   task automatic tick_collide(input string tag, input logic [15:0] v, input bit do_clear);
      model_load(v, do_clear);
      push_all(tag);
      clk_slow = 1'b1;
      repeat (3) @(negedge clk_50MHz);
      clear    = do_clear;
      load     = 1'b1;
      load_bcd = v;
      @(negedge clk_50MHz);
      clear = 1'b0;
      load  = 1'b0;
      drain();
      @(negedge clk_50MHz);
      check_hex(tag);
      clk_slow = 1'b0;
      repeat (3) @(negedge clk_50MHz);
   endtask

   initial begin
      reset    = 1'b1;
      clk_slow = 1'b1;
      enable   = 1'b1;
      up_down  = 1'b1;
      clear    = 1'b0;
      load     = 1'b0;
      load_bcd = '0;
      model_reset();
      repeat (3) @(negedge clk_50MHz);
      push_all("rst");
      drain();
      check_hex("rst");
      reset = 1'b0;
      repeat (8) @(negedge clk_50MHz);
      push_all("arm_hi");
      drain();
      clk_slow = 1'b0;
      repeat (3) @(negedge clk_50MHz);
      tick("first");

      load_op("ld0999", 16'h0999, 1'b0, 1'b1);
      tick("up_carry");
      load_op("ld9999", 16'h9999, 1'b0, 1'b1);
      tick("up_wrap");
      up_down = 1'b0;
      tick("dn_wrap");
      tick("dn_borrow");
      load_op("ldA5F3", 16'hA5F3, 1'b0, 1'b1);
      load_op("ld0100", 16'h0100, 1'b0, 1'b1);
      tick("dn_0100");
      load_op("ld0042", 16'h0042, 1'b0, 1'b1);

      enable = 1'b0;
      for (int i = 0; i < 3; i++) tick($sformatf("dis%0d", i));
      enable = 1'b1;

      up_down = 1'b1;
      tick_collide("clr_ld_tick", 16'h0321, 1'b1);
      tick_collide("ld_tick", 16'h0500, 1'b0);
      tick("up_0500");
      load_op("clr", 16'h1234, 1'b1, 1'b0);

      load_op("ld0777", 16'h0777, 1'b0, 1'b1);
      @(posedge clk_50MHz);
      #3 reset = 1'b1;
      #1;
      model_reset();
      push_all("mid_rst");
      drain();
      @(negedge clk_50MHz);
      reset = 1'b0;
      repeat (5) @(negedge clk_50MHz);
      tick("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
